// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Input/output handshake bundle for the bin2bcd_seq converter.
// Revision    : 1.0
// ============================================================================
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sign_out;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, sign_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, sign_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative double-dabble binary-to-BCD converter, one bit/clock,
//               valid/ready on both sides, optional sign+magnitude mode.
// Revision    : 1.0
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input wire clk,
  input wire rst,
  bin2bcd_seq_if.slave bus
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  // Exact check for narrow inputs, log10(2) bound once 2**bw overflows 64 bits.
  function automatic bit f_digits_fit(input int bw, input int dg);
    longint unsigned p;
    longint unsigned lim;
    if (bw >= 60) begin
      return (longint'(dg) * 100000) >= (longint'(bw) * 30103);
    end
    p   = 1;
    lim = longint'(1) << bw;
    for (int i = 0; i < dg; i++) begin
      if (p >= lim) break;
      p = p * 10;
    end
    return p >= lim;
  endfunction

  generate
    if (BIN_W < 2) begin : g_bad_width
      $error("bin2bcd_seq: BIN_W must be at least 2");
    end
    if (!f_digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [BIN_W-1:0]    r_shift;
  logic [c_bcd_w-1:0]  r_bcd;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_sign;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;
  logic                w_accept;
  logic                w_sign;
  logic [BIN_W-1:0]    w_mag;
  logic [c_bcd_w-1:0]  w_adj;

  assign w_accept = bus.in_valid && w_in_ready;

  // Two's-complement negate keeps the most-negative value as 2**(BIN_W-1).
  assign w_sign = (SIGNED != 0) && bus.bin_in[BIN_W-1];
  assign w_mag  = w_sign ? (~bus.bin_in + {{(BIN_W-1){1'b0}}, 1'b1}) : bus.bin_in;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                           : r_bcd[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (bus.in_valid) w_state_nxt = c_st_shift;
      c_st_shift: if (r_cnt == c_cnt_w'(1)) w_state_nxt = c_st_done;
      c_st_done:  if (bus.out_ready) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      c_st_idle:  w_in_ready  = !rst;
      c_st_shift: w_busy      = 1'b1;
      c_st_done:  w_out_valid = 1'b1;
      default:    w_in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
    end else if (w_accept) begin
      r_shift <= w_mag;
      r_bcd   <= '0;
      r_cnt   <= c_cnt_w'(BIN_W);
      r_sign  <= w_sign;
    end else if (r_state == c_st_shift) begin
      r_bcd   <= {w_adj[c_bcd_w-2:0], r_shift[BIN_W-1]};
      r_shift <= {r_shift[BIN_W-2:0], 1'b0};
      r_cnt   <= r_cnt - c_cnt_w'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.bcd_out   = r_bcd;
  assign bus.sign_out  = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq: unsigned 8-bit, signed
//               8-bit and unsigned 16-bit instances against a decimal model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        t_valid;
  logic        t_oready;
  logic [15:0] t_bin;
  int          sel;

  logic        m_in_ready, m_out_valid, m_sign, m_busy;
  logic [19:0] m_bcd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if_u ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if_s ();
  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if_w ();

  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(if_u));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(if_s));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_dut_w (.clk(clk), .rst(rst), .bus(if_w));

  // Only the selected instance sees valid/ready; the others sit idle.
  assign if_u.in_valid  = t_valid  && (sel == 0);
  assign if_u.out_ready = t_oready && (sel == 0);
  assign if_u.bin_in    = t_bin[7:0];
  assign if_s.in_valid  = t_valid  && (sel == 1);
  assign if_s.out_ready = t_oready && (sel == 1);
  assign if_s.bin_in    = t_bin[7:0];
  assign if_w.in_valid  = t_valid  && (sel == 2);
  assign if_w.out_ready = t_oready && (sel == 2);
  assign if_w.bin_in    = t_bin;

  always_comb begin
    m_in_ready  = if_u.in_ready;
    m_out_valid = if_u.out_valid;
    m_bcd       = {8'd0, if_u.bcd_out};
    m_sign      = if_u.sign_out;
    m_busy      = if_u.busy;
    case (sel)
      1: begin
        m_in_ready  = if_s.in_ready;
        m_out_valid = if_s.out_valid;
        m_bcd       = {8'd0, if_s.bcd_out};
        m_sign      = if_s.sign_out;
        m_busy      = if_s.busy;
      end
      2: begin
        m_in_ready  = if_w.in_ready;
        m_out_valid = if_w.out_valid;
        m_bcd       = if_w.bcd_out;
        m_sign      = if_w.sign_out;
        m_busy      = if_w.busy;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_w();
    return (sel == 2) ? 16 : 8;
  endfunction

  function automatic bit ref_neg(input int unsigned v);
    return (sel == 1) && (v >= (32'd1 << (cur_w() - 1)));
  endfunction

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    int unsigned mag;
    logic [19:0] r;
    mag = ref_neg(v) ? ((32'd1 << cur_w()) - v) : v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  // One complete transaction: accept, measure latency/busy, hold, handshake.
  task automatic run_conv(input int unsigned v, input int hold);
    int n, cyc, busy_cnt;
    logic [19:0] exp_bcd;
    exp_bcd = ref_bcd(v);
    n = 0;
    while (!m_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", m_in_ready, 1);
    t_bin   = 16'(v);
    t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    t_bin   = 16'($urandom);
    cyc = 0;
    busy_cnt = 0;
    while (!m_out_valid && cyc < 100) begin
      if (m_busy) busy_cnt++;
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, cur_w());
    check("busy_cycles", busy_cnt, cur_w());
    check("bcd", m_bcd, exp_bcd);
    check("sign", m_sign, ref_neg(v));
    check("in_ready_done", m_in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", m_out_valid, 1);
      check("hold_bcd", m_bcd, exp_bcd);
    end
    t_oready = 1'b1;
    @(posedge clk); #1;
    t_oready = 1'b0;
    check("post_valid", m_out_valid, 0);
    check("post_in_ready", m_in_ready, 1);
    check("post_bcd", m_bcd, exp_bcd);
  endtask

  task automatic run_b2b();
    int unsigned q[$];
    int unsigned v;
    int cyc, last_acc, nres;
    logic acc, dn, got_sign;
    logic [19:0] got_bcd;
    logic [15:0] vb;
    cyc = 0; last_acc = -1; nres = 0;
    t_bin = 16'($urandom);
    t_valid = 1'b1;
    t_oready = 1'b1;
    while (nres < 8 && cyc < 1000) begin
      acc = m_in_ready; dn = m_out_valid; got_bcd = m_bcd; got_sign = m_sign; vb = t_bin;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        q.push_back(int'(vb));
        if (last_acc >= 0) check("b2b_gap", cyc - last_acc, 18);
        last_acc = cyc;
        t_bin = 16'($urandom);
      end
      if (dn) begin
        if (q.size() == 0) begin
          check("b2b_spurious", 1, 0);
        end else begin
          v = q.pop_front();
          check("b2b_bcd", got_bcd, ref_bcd(v));
          check("b2b_sign", got_sign, 0);
        end
        nres++;
      end
    end
    check("b2b_count", nres, 8);
    t_valid = 1'b0;
    t_oready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rose;
    rst = 1'b1; t_valid = 1'b0; t_oready = 1'b0; t_bin = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", m_in_ready, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_bcd", m_bcd, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", m_in_ready, 1);
    check("idle_busy", m_busy, 0);

    // Unsigned 8-bit instance: directed corners, hold, then random.
    run_conv(255, 0);
    run_conv(0, 0);
    run_conv(99, 0);
    run_conv(137, 5);

    t_bin = 16'd200;
    t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", m_busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", m_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_valid", m_out_valid, 0);
    check("rst_mid_bcd", m_bcd, 0);
    check("rst_mid_sign", m_sign, 0);
    check("rst_mid_busy", m_busy, 0);
    check("rst_mid_in_ready_rel", m_in_ready, 1);
    rose = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_out_valid) rose = 1'b1;
    end
    check("rst_no_valid", rose, 0);
    run_conv(42, 0);
    for (int i = 0; i < 12; i++) run_conv($urandom_range(0, 255), $urandom_range(0, 2));

    // Signed 8-bit instance.
    sel = 1;
    #1;
    run_conv(32'h80, 0);
    run_conv(32'hF9, 0);
    run_conv(32'h7F, 0);
    for (int i = 0; i < 12; i++) run_conv($urandom_range(0, 255), $urandom_range(0, 2));

    // Wide unsigned instance, including back-to-back traffic.
    sel = 2;
    #1;
    run_conv(65535, 0);
    for (int i = 0; i < 10; i++) run_conv($urandom_range(0, 65535), $urandom_range(0, 2));
    run_b2b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
